// File: rtl/blockade_ioctl_pkg.sv
// Shared ioctl definitions for the blockade core.
// Upload FSM states, fill byte and ioctl index map.
package blockade_ioctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_DONE
    } upload_state_e;

    localparam logic [7:0] FILL_BYTE         = 8'hFF;

    localparam logic [7:0] IOCTL_IDX_ROM     = 8'd0;
    localparam logic [7:0] IOCTL_IDX_CORE    = 8'd1;
    localparam logic [7:0] IOCTL_IDX_HISCORE = 8'd4;

    function automatic logic [7:0] twos_neg(input logic [7:0] v);
        return 8'(~v + 8'd1);
    endfunction

endpackage

// File: rtl/upload_timeout_ctr.sv
// Grant-wait cycle counter for the hiscore upload block.
// Ports: i_clk, i_rst_n (async, active-low), i_load (clear to zero),
//        i_enable (count one waiting cycle), o_expired (this cycle is
//        the TIMEOUT-th waiting cycle).
module upload_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Count holds the number of waiting cycles already completed,
    // so the TIMEOUT-th waiting cycle is the one seeing LAST.
    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/hiscore_upload.sv
// Serves HPS ioctl upload byte reads from the game work RAM.
// Ports: clk_sys, nRESET (async, active-low); ioctl_upload/rd/addr/index
//        in, ioctl_din/ioctl_wait out; ram_req/ram_addr out, ram_gnt/ram_q
//        in; err = sticky grant-timeout flag.
// Option: define HISCORE_UPLOAD_CHECKSUM_EN to add a running byte sum;
//         a read at address DEPTH then returns its two's complement.
module hiscore_upload
    import blockade_ioctl_pkg::*;
#(
    parameter int         ADDR_W  = 10,
    parameter logic [7:0] INDEX   = IOCTL_IDX_HISCORE,
    parameter int         RAM_LAT = 1,
    parameter int         TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              nRESET,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ram_req,
    input  logic              ram_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_q,
    output logic              err
);

    localparam logic [24:0] DEPTH    = 25'(1) << ADDR_W;
    localparam logic [1:0]  LAT_LAST = 2'(RAM_LAT - 1);

    upload_state_e     r_state;
    upload_state_e     w_state_nxt;
    logic [7:0]        r_din;
    logic [7:0]        w_din_nxt;
    logic              r_wait;
    logic              w_wait_nxt;
    logic              r_req;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [1:0]        r_lat;
    logic [1:0]        w_lat_nxt;
    logic              r_upload_d;

    logic w_upload_rise;
    logic w_accept;
    logic w_in_range;
    logic w_to_load;
    logic w_to_en;
    logic w_to_expired;

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_nxt;
`endif

    assign w_upload_rise = ioctl_upload & ~r_upload_d;
    assign w_accept      = ioctl_upload & ioctl_rd &
                           (ioctl_index == INDEX);
    assign w_in_range    = (ioctl_addr < DEPTH);

    // Counter sits at zero outside REQ, so each REQ visit starts fresh.
    assign w_to_load = (r_state != ST_REQ);
    assign w_to_en   = (r_state == ST_REQ) & ~ram_gnt;

    upload_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (clk_sys),
        .i_rst_n   (nRESET),
        .i_load    (w_to_load),
        .i_enable  (w_to_en),
        .o_expired (w_to_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_din_nxt   = r_din;
        w_wait_nxt  = r_wait;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_err_nxt   = r_err;
        w_lat_nxt   = r_lat;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
        w_sum_nxt   = r_sum;
        if (w_upload_rise) begin
            w_sum_nxt = 8'h00;
        end
`endif
        if (w_upload_rise) begin
            w_err_nxt = 1'b0;
        end

        if (!ioctl_upload) begin
            // Session abort: release everything, keep the last byte.
            w_state_nxt = ST_IDLE;
            w_wait_nxt  = 1'b0;
            w_req_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_in_range) begin
                        w_addr_nxt  = ioctl_addr[ADDR_W-1:0];
                        w_wait_nxt  = 1'b1;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else if (w_accept) begin
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
                        w_din_nxt = (ioctl_addr == DEPTH) ?
                                    twos_neg(w_sum_nxt) : FILL_BYTE;
`else
                        w_din_nxt = FILL_BYTE;
`endif
                    end
                end
                ST_REQ: begin
                    if (ram_gnt) begin
                        w_lat_nxt   = 2'd0;
                        w_state_nxt = ST_READ;
                    end else if (w_to_expired) begin
                        w_din_nxt   = FILL_BYTE;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_READ: begin
                    // ram_q is held by the arbiter for the granted
                    // window, so a dropped grant here is harmless.
                    if (r_lat == LAT_LAST) begin
                        w_din_nxt   = ram_q;
`ifdef HISCORE_UPLOAD_CHECKSUM_EN
                        w_sum_nxt   = r_sum + ram_q;
`endif
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_lat_nxt = r_lat + 2'd1;
                    end
                end
                ST_DONE: begin
                    w_wait_nxt  = 1'b0;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_state    <= ST_IDLE;
            r_din      <= 8'h00;
            r_wait     <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_err      <= 1'b0;
            r_lat      <= 2'd0;
            r_upload_d <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_din      <= w_din_nxt;
            r_wait     <= w_wait_nxt;
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_err      <= w_err_nxt;
            r_lat      <= w_lat_nxt;
            r_upload_d <= ioctl_upload;
        end
    end

`ifdef HISCORE_UPLOAD_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            r_sum <= 8'h00;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign ram_req    = r_req;
    assign ram_addr   = r_addr;
    assign err        = r_err;

endmodule
